// File: rtl/stream_mux_reg_pkg.sv
// rtl/stream_mux_reg_pkg.sv - shared mode constants and width helper for stream_mux_reg
package stream_mux_reg_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Index width for n channels, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_reg_rr_pick.sv
// rtl/stream_mux_reg_rr_pick.sv - rotating priority encoder: first valid at or after ptr
module rr_pick
  import stream_mux_reg_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2_min1(N)
) (
  input  logic [N-1:0]    valid_i,
  input  logic [SELW-1:0] ptr_i,
  output logic            any_o,
  output logic [SELW-1:0] idx_o
);

  always_comb begin : pick
    int k;
    any_o = 1'b0;
    idx_o = '0;
    k     = 0;
    // Scan farthest-first so the closest hit to ptr is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % N;
      if (valid_i[k]) begin
        any_o = 1'b1;
        idx_o = k[SELW-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_mux_reg.sv
// rtl/stream_mux_reg.sv - N-way valid/ready stream mux with one registered output slot
module stream_mux_reg
  import stream_mux_reg_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int MODE = MODE_SEL,
  parameter int SELW = clog2_min1(N)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            flush_i,
  input  logic [SELW-1:0] sel_i,
  input  logic [N-1:0]    in_valid_i,
  input  logic [N*W-1:0]  in_data_i,
  output logic [N-1:0]    in_ready_o,
  output logic            out_valid_o,
  output logic [W-1:0]    out_data_o,
  output logic [SELW-1:0] out_chan_o,
  input  logic            out_ready_i,
  output logic            sel_err_o
);

  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_chan_q, out_chan_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic            sel_err_q, sel_err_d;

  logic            rr_any;
  logic [SELW-1:0] rr_idx;
  logic            grant_valid;
  logic [SELW-1:0] g;
  logic [W-1:0]    g_data;
  logic            free;
  logic            xfer;

  rr_pick #(.N(N), .SELW(SELW)) u_rr_pick (
    .valid_i (in_valid_i),
    .ptr_i   (rr_ptr_q),
    .any_o   (rr_any),
    .idx_o   (rr_idx)
  );

  always_comb begin
    grant_valid = 1'b0;
    g           = '0;
    if (MODE == MODE_RR) begin
      grant_valid = rr_any;
      g           = rr_idx;
    end else begin
      g = sel_i;
      // Out-of-range select matches no channel, so no grant.
      for (int k = 0; k < N; k++) begin
        if (sel_i == SELW'(k)) grant_valid = in_valid_i[k];
      end
    end
  end

  assign free = !out_valid_q || out_ready_i;
  assign xfer = free && !flush_i && grant_valid;

  always_comb begin
    in_ready_o = '0;
    g_data     = '0;
    for (int k = 0; k < N; k++) begin
      if (g == SELW'(k)) begin
        in_ready_o[k] = xfer;
        g_data        = in_data_i[k*W +: W];
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = g_data;
      out_chan_d  = g;
      if (MODE == MODE_RR) rr_ptr_d = (int'(g) == N - 1) ? '0 : g + SELW'(1);
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
    sel_err_d = (MODE == MODE_SEL) && (int'(sel_i) >= N);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_chan_o  = out_chan_q;
  assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_stream_mux_reg.sv
// tb/tb_stream_mux_reg.sv - directed bench for stream_mux_reg in select, round-robin and N=3 configurations
module tb_stream_mux_reg;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // A: MODE 0, N=4, W=32
  logic        a_flush, a_or, a_ov, a_se;
  logic [1:0]  a_sel, a_oc;
  logic [3:0]  a_iv, a_ir;
  logic [127:0] a_id;
  logic [31:0] a_od;
  // B: MODE 1, N=4, W=32
  logic        b_flush, b_or, b_ov, b_se;
  logic [1:0]  b_sel, b_oc;
  logic [3:0]  b_iv, b_ir;
  logic [127:0] b_id;
  logic [31:0] b_od;
  // C: MODE 0, N=3, W=8
  logic        c_flush, c_or, c_ov, c_se;
  logic [1:0]  c_sel, c_oc;
  logic [2:0]  c_iv, c_ir;
  logic [23:0] c_id;
  logic [7:0]  c_od;

  stream_mux_reg #(.N(4), .W(32), .MODE(0)) dut_a (
    .clk_i(clk), .reset_i(rst), .flush_i(a_flush), .sel_i(a_sel),
    .in_valid_i(a_iv), .in_data_i(a_id), .in_ready_o(a_ir),
    .out_valid_o(a_ov), .out_data_o(a_od), .out_chan_o(a_oc),
    .out_ready_i(a_or), .sel_err_o(a_se));

  stream_mux_reg #(.N(4), .W(32), .MODE(1)) dut_b (
    .clk_i(clk), .reset_i(rst), .flush_i(b_flush), .sel_i(b_sel),
    .in_valid_i(b_iv), .in_data_i(b_id), .in_ready_o(b_ir),
    .out_valid_o(b_ov), .out_data_o(b_od), .out_chan_o(b_oc),
    .out_ready_i(b_or), .sel_err_o(b_se));

  stream_mux_reg #(.N(3), .W(8), .MODE(0)) dut_c (
    .clk_i(clk), .reset_i(rst), .flush_i(c_flush), .sel_i(c_sel),
    .in_valid_i(c_iv), .in_data_i(c_id), .in_ready_o(c_ir),
    .out_valid_o(c_ov), .out_data_o(c_od), .out_chan_o(c_oc),
    .out_ready_i(c_or), .sel_err_o(c_se));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] d [4];
  logic [1:0]  rr_seq [5];
  logic [1:0]  nb_sel [3];

  initial begin
    d[0] = 32'h1111_0000; d[1] = 32'h1111_1111; d[2] = 32'hDEAD_BEEF; d[3] = 32'h3333_3333;
    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd2; rr_seq[3] = 2'd3; rr_seq[4] = 2'd0;
    nb_sel[0] = 2'd0; nb_sel[1] = 2'd1; nb_sel[2] = 2'd2;
    a_flush = 0; a_or = 0; a_sel = 0; a_iv = 0; a_id = {d[3], d[2], d[1], d[0]};
    b_flush = 0; b_or = 0; b_sel = 0; b_iv = 0; b_id = {d[3], d[2], d[1], d[0]};
    c_flush = 0; c_or = 0; c_sel = 0; c_iv = 0; c_id = 24'hC2_C1_C0;

    #1;
    check("rst_a_ov", a_ov, 0);
    check("rst_a_se", a_se, 0);
    check("rst_b_oc", b_oc, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_a_ov", a_ov, 0);
      check("idle_a_od", a_od, 0);
      check("idle_a_ir", a_ir, 0);
    end

    // Select mode: single load then drain
    a_sel = 2; a_iv = 4'b0100; a_or = 1;
    #1 check("sel2_ir", a_ir, 4'b0100);
    tick();
    check("sel2_ov", a_ov, 1);
    check("sel2_od", a_od, 32'hDEAD_BEEF);
    check("sel2_oc", a_oc, 2);
    a_sel = 1;
    #1 check("sel1_ir", a_ir, 0);
    tick();
    check("drain_ov", a_ov, 0);
    check("drain_od_hold", a_od, 32'hDEAD_BEEF);

    // Stall with all channels valid
    a_sel = 3; a_iv = 4'b1111;
    tick();
    check("load3_od", a_od, d[3]);
    a_or = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_ir", a_ir, 0);
      tick();
      check("stall_ov", a_ov, 1);
      check("stall_od", a_od, d[3]);
    end
    a_or = 1;
    for (int i = 0; i < 3; i++) begin
      a_sel = nb_sel[i];
      #1 check("nb_ir", a_ir, 4'b0001 << nb_sel[i]);
      tick();
      check("nb_ov", a_ov, 1);
      check("nb_oc", a_oc, nb_sel[i]);
      check("nb_od", a_od, d[nb_sel[i]]);
    end

    // Round-robin
    b_or = 1; b_iv = 4'b1111;
    #1 check("rr_ir0", b_ir, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rr_oc", b_oc, rr_seq[i]);
      check("rr_od", b_od, d[rr_seq[i]]);
    end
    b_iv = 4'b1001;
    #1 check("rr9_ir", b_ir, 4'b1000);
    tick(); check("rr9_oc_a", b_oc, 3);
    tick(); check("rr9_oc_b", b_oc, 0);
    tick(); check("rr9_oc_c", b_oc, 3);

    // Flush while slot holds channel 2 (pointer becomes 3)
    b_iv = 4'b0100;
    tick(); check("fl_load_oc", b_oc, 2);
    b_iv = 4'b0001; b_flush = 1;
    #1 check("fl_ir", b_ir, 0);
    tick();
    check("fl_ov", b_ov, 0);
    b_flush = 0; b_iv = 4'b1111;
    #1 check("fl_ptr_ir", b_ir, 4'b1000);
    b_iv = 4'b0001;
    #1 check("fl_ch0_ir", b_ir, 4'b0001);
    tick();
    check("fl_ch0_ov", b_ov, 1);
    check("fl_ch0_oc", b_oc, 0);
    b_iv = 0;

    // N=3 out-of-range select
    check("c_se_idle", c_se, 0);
    c_sel = 3; c_iv = 3'b111; c_or = 1;
    #1 check("c_ir_bad", c_ir, 0);
    tick();
    check("c_se_set", c_se, 1);
    check("c_ov_bad", c_ov, 0);
    c_sel = 1;
    #1 check("c_ir_ok", c_ir, 3'b010);
    tick();
    check("c_se_clr", c_se, 0);
    check("c_oc", c_oc, 1);
    check("c_od", c_od, 8'hC1);

    // Async reset mid-stall
    a_or = 0;
    #2 check("ar_pre_ov", a_ov, 1);
    rst = 1'b1;
    #1;
    check("ar_ov", a_ov, 0);
    check("ar_od", a_od, 0);
    check("ar_oc", a_oc, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stream_mux_reg.md
Name: stream_mux_reg

Overview:
- Parametrised N-channel, W-bit multiplexer with valid/ready handshake on every input and on the output, and one registered output stage.
- Supersedes the fixed 2/4/8/16-way combinational selectors wherever a source may be not-yet-valid or a sink may stall. Examples: shared bus-request funnel, multi-source write-back collection.
- Two modes:
  - Select-driven: an external `sel` chooses the channel.
  - Round-robin: fair arbitration among valid inputs.

Parameters:
- N, 4, number of input channels (2..16).
- W, 32, data width per channel.
- MODE, 0, 0 = select-driven by `sel`; 1 = round-robin (`sel` ignored).
- SELW, clog2(N) with minimum 1, width of `sel` and `out_chan`.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of the output slot
- sel  in  SELW  channel select (MODE 0 only)
- in_valid  in  N  per-channel valid
- in_data  in  N*W  channel k occupies bits [k*W+W-1 : k*W]
- in_ready  out  N  per-channel accept (combinational)
- out_valid  out  1  output slot holds data
- out_data  out  W  registered data
- out_chan  out  SELW  index of the channel that supplied out_data
- out_ready  in  1  sink accepts out_data this cycle
- sel_err  out  1  registered flag: previous cycle had MODE 0 and sel >= N

Behaviour:
- Reset (async, immediate): out_valid=0, out_data=0, out_chan=0, sel_err=0, rr_ptr=0. in_ready is combinational and therefore 0 while out of reset with no grant.
- Slot free: free = !out_valid || out_ready.
- Grant in MODE 0: grant valid iff sel < N and in_valid[sel]; g = sel.
- Grant in MODE 1: g = first k with in_valid[k], scanning rr_ptr, rr_ptr+1, ... N-1, 0, ... rr_ptr-1. Grant valid iff any in_valid.
- in_ready[k] = free && !flush && grant valid && (k == g). At most one bit is set. All bits are 0 otherwise.
- Transfer (in_valid[g] && in_ready[g]) on a rising edge:
  - out_data <= channel g data
  - out_chan <= g
  - out_valid <= 1
- Latency: 1 cycle from input handshake to out_valid.
- Throughput: 1 transfer per cycle when out_ready is held high. Back-to-back transfers need no bubble.
- Output drain without reload (out_valid && out_ready, no transfer): out_valid <= 0. out_data and out_chan hold their last values.
- Stall (out_valid && !out_ready): out_data and out_chan are stable. No input is accepted.
- Flush has priority over everything:
  - out_valid <= 0
  - no input accepted that cycle
  - rr_ptr unchanged
- Simultaneous drain and load: the new data replaces the old. out_valid stays 1.
- rr_ptr (MODE 1): on a transfer only, rr_ptr <= (g == N-1) ? 0 : g+1. It is unchanged on stall, idle or flush. In MODE 0, rr_ptr stays 0.
- sel_err <= (MODE == 0) && (sel >= N), every cycle.
  - Only possible when N is not a power of two.
  - Informational only; no grant is made.
- Input rules: in_valid may drop without handshake. The block never latches unaccepted data.
- Reset mid-stall discards the slot contents.

Decomposition:
- Shared package/header: MODE_SEL=0 and MODE_RR=1 constants, plus a clog2 helper function.
- One sub-module, rr_pick:
  - parameter N
  - inputs: valid[N-1:0], ptr[SELW-1:0]
  - outputs: any, idx[SELW-1:0]
  - purely combinational rotate/priority-encode
- The top level holds the slot register, rr_ptr, sel_err and the handshake logic.

Test Plan:
- Reset release, all in_valid=0: out_valid=0, out_data=0, in_ready=0 for 5 cycles.
- MODE 0, N=4, sel=2, in_valid=4'b0100, data2=0xDEADBEEF, out_ready=1:
  - in_ready=4'b0100
  - next cycle out_valid=1, out_data=0xDEADBEEF, out_chan=2
  - change sel to 1 with in_valid[1]=0 → out_valid drops to 0 the following cycle
- Stall: slot full, out_ready=0 for 3 cycles while in_valid=4'b1111:
  - in_ready=0
  - out_data unchanged
  - raise out_ready → one drain+load per cycle, no bubble
- MODE 1, N=4, in_valid=4'b1111 held, out_ready=1:
  - out_chan sequence 0,1,2,3,0
  - then in_valid=4'b1001 from ptr=1 → grants 3, then 0, then 3
- Flush asserted while slot holds chan 2 with in_valid=4'b0001:
  - in_ready=0 that cycle
  - next cycle out_valid=0, rr_ptr unchanged
  - the cycle after, channel 0 is accepted
- MODE 0, N=3, sel=3:
  - no in_ready bit set
  - sel_err=1 one cycle later, and 0 one cycle after sel returns to 1
- Async reset asserted mid-stall (no clock edge) → out_valid falls immediately.
